// File: rtl/seg7_pkg.sv
// Shared seven-segment display types and the BCD-to-segment decoder.
// Segment bit order is {g,f,e,d,c,b,a}, and all values here are active-high.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam bcd_t       BCD_MAX   = 4'd9;

  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    case (d)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD digit register that counts up or down by one.
// It has ripple carry/borrow in and out, and a parallel load that clamps digits above 9 down to 9.
module bcd_decade
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_digit,
  input  logic up,
  input  logic cin,
  output bcd_t digit,
  output logic cout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_digit > BCD_MAX) ? BCD_MAX : load_digit;
    end else if (cin) begin
      if (up) digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

  // The carry or borrow ripples combinationally, so a whole-number step settles within one clock.
  assign cout = cin & (up ? (digit == BCD_MAX) : (digit == 4'd0));

endmodule

// File: rtl/bcd_counter_mux_display.sv
// Multi-digit BCD up/down counter that drives a time-multiplexed seven-segment display.
// The display is scanned one digit at a time, and leading zeros can be blanked.
module bcd_counter_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE_BITS  = 25,
  parameter int SCAN_BITS      = 16,
  parameter int WRAP           = 1,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       up_n_down,
  input  logic                       step,
  input  logic                       load,
  input  logic [NUM_DIGITS-1:0][3:0] load_value,
  output logic [NUM_DIGITS-1:0][3:0] bcd_value,
  output logic                       at_limit,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      digit_sel
);

  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL   = (SEG_ACTIVE_LOW != 0);

  logic                  count_event;
  logic                  step_eff;
  logic [NUM_DIGITS-1:0] carry;
  logic                  all_nine;
  logic                  all_zero;

  if (PRESCALE_BITS > 0) begin : g_prescale
    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     unused_step;

    always_ff @(posedge clk) begin
      if (reset)       prescaler <= '0;
      else if (enable) prescaler <= prescaler + PRESCALE_BITS'(1);
    end

    assign count_event = enable & (&prescaler);
    assign unused_step = step;
  end else begin : g_step
    assign count_event = step & enable;
  end

  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_nine = all_nine & (bcd_value[i] == BCD_MAX);
      all_zero = all_zero & (bcd_value[i] == 4'd0);
    end
  end

  assign at_limit = up_n_down ? all_nine : all_zero;
  // In saturate mode, an event at the limit is simply dropped, so the value holds.
  assign step_eff = count_event & ((WRAP != 0) | ~at_limit);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_decade u_decade (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (load_value[i]),
      .up         (up_n_down),
      .cin        ((i == 0) ? step_eff : carry[(i == 0) ? 0 : i-1]),
      .digit      (bcd_value[i]),
      .cout       (carry[i])
    );
  end

  logic unused_carry;
  assign unused_carry = carry[NUM_DIGITS-1];

  logic [SCAN_BITS-1:0] scan_cnt;
  logic [IDX_W-1:0]     scan_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_BITS'(1);
      if (&scan_cnt)
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS-1)) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  logic [NUM_DIGITS:1]   zero_above;
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    zero_above             = '0;
    zero_above[NUM_DIGITS] = (bcd_value[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS-1; i >= 1; i--)
      zero_above[i] = zero_above[i+1] & (bcd_value[i-1] == 4'd0);
    blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      blank[i] = (BLANK_LEADING != 0) & zero_above[i+1];
  end

  bcd_t                  cur_digit;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] sel_hi;

  always_comb begin
    cur_digit        = bcd_value[scan_idx];
    seg_hi           = blank[scan_idx] ? SEG_BLANK : bcd_to_seg(cur_digit);
    sel_hi           = '0;
    sel_hi[scan_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg       <= SEG_BLANK ^ {7{POL}};
      digit_sel <= {NUM_DIGITS{POL}};
    end else begin
      seg       <= seg_hi ^ {7{POL}};
      digit_sel <= sel_hi ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
// Scoreboard bench for bcd_counter_mux_display.
// Two instances share one stimulus: dut wraps at the limits and dut_sat saturates.
module tb_bcd_counter_mux_display;

  localparam int ND = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                up_n_down = 1'b1;
  logic                step = 1'b0;
  logic                load = 1'b0;
  logic [ND-1:0][3:0]  load_value = '0;

  logic [ND-1:0][3:0]  bcd, bcd_s;
  logic                lim, lim_s;
  logic [6:0]          seg, seg_s;
  logic [ND-1:0]       sel, sel_s;

  bcd_counter_mux_display #(
    .NUM_DIGITS(ND), .PRESCALE_BITS(0), .SCAN_BITS(1),
    .WRAP(1), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_n_down(up_n_down),
    .step(step), .load(load), .load_value(load_value),
    .bcd_value(bcd), .at_limit(lim), .seg(seg), .digit_sel(sel)
  );

  bcd_counter_mux_display #(
    .NUM_DIGITS(ND), .PRESCALE_BITS(0), .SCAN_BITS(1),
    .WRAP(0), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)
  ) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_n_down(up_n_down),
    .step(step), .load(load), .load_value(load_value),
    .bcd_value(bcd_s), .at_limit(lim_s), .seg(seg_s), .digit_sel(sel_s)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; this is the bench's model of the scan phase.
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;
  int v     = 0;
  int vs    = 0;
  int q_main[$];
  int q_sat[$];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int next_val(input int x, input bit up, input bit wrap);
    if (up) return (x == 99) ? (wrap ? 0 : 99) : x + 1;
    else    return (x == 0)  ? (wrap ? 99 : 0) : x - 1;
  endfunction

  // One stimulus cycle followed by one idle cycle, with the result checked after the idle cycle.
  task automatic drive(input bit st, input bit ld, input logic [7:0] lv);
    int h, l, e;
    @(negedge clk);
    check("at_limit", lim, up_n_down ? (v == 99) : (v == 0));
    check("at_limit_sat", lim_s, up_n_down ? (vs == 99) : (vs == 0));
    step = st; load = ld; load_value = lv;
    if (ld) begin
      h = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
      l = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
      v = h * 10 + l;
      vs = v;
    end else if (st && enable) begin
      v  = next_val(v, up_n_down, 1'b1);
      vs = next_val(vs, up_n_down, 1'b0);
    end
    q_main.push_back(v);
    q_sat.push_back(vs);
    @(negedge clk);
    step = 1'b0; load = 1'b0;
    if (q_main.size() == 0 || q_sat.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = q_main.pop_front();
      check("bcd", bcd, to_bcd(e));
      e = q_sat.pop_front();
      check("bcd_sat", bcd_s, to_bcd(e));
    end
  endtask

  task automatic scan_check(input int n);
    int idx, d;
    logic [6:0] es;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idx = ((cyc - 1) / 2) % 2;
      d   = (idx == 1) ? v / 10 : v % 10;
      es  = (idx == 1 && v / 10 == 0) ? 7'h00 : seg_tab[d];
      check("digit_sel", sel, 32'(1 << idx));
      check("seg", seg, es);
    end
  endtask

  task automatic reset_check();
    check("rst_bcd", bcd, 0);
    check("rst_bcd_sat", bcd_s, 0);
    check("rst_seg", seg, 0);
    check("rst_sel", sel, 0);
    check("rst_seg_sat", seg_s, 0);
    check("rst_sel_sat", sel_s, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      reset_check();
    end
    reset = 1'b0;
    v = 0; vs = 0;
    scan_check(4);

    enable = 1'b1; up_n_down = 1'b1;
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 8'h00);

    up_n_down = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h99);
    up_n_down = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    up_n_down = 1'b0;
    drive(1'b1, 1'b0, 8'h00);

    up_n_down = 1'b1;
    drive(1'b1, 1'b1, 8'hC3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h25);
    enable = 1'b1;

    drive(1'b0, 1'b1, 8'h07);
    scan_check(6);
    drive(1'b0, 1'b1, 8'h70);
    scan_check(6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset_check();
    v = 0; vs = 0;
    reset = 1'b0;
    scan_check(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
